// File: rtl/two_digit_sequencer.sv
// Two-digit BCD up/down counter with start/stop, load and direction buttons.
// Count steps once every TICK_DIV clocks while running; the display shows the
// count on two seven-segment digits, or dashes after an invalid load.
module two_digit_sequencer #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [7:0] SW,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0,
    output logic [9:0] LEDR
);

    localparam int            PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [6:0]    DASH = 7'b0111111;

    typedef enum logic [1:0] {IDLE, RUN, HOLD, ERROR} state_t;

    state_t        state;
    logic [7:0]    count;
    logic          dir_up;
    logic [PW-1:0] presc;

    logic          rst_p0, rst_p1;
    logic          rst_n;
    logic [2:0]    key_p0, key_p1, key_p2;
    logic [2:0]    press;
    logic          ss_pulse, load_pulse, dir_pulse;
    logic          sw_ok;

    // One BCD step in the requested direction, wrapping 99<->00.
    function automatic logic [7:0] bcd_step(input logic [7:0] c, input logic up);
        logic [3:0] t, u;
        t = c[7:4];
        u = c[3:0];
        if (up) begin
            if (u == 4'd9) begin
                u = 4'd0;
                t = (t == 4'd9) ? 4'd0 : t + 4'd1;
            end else begin
                u = u + 4'd1;
            end
        end else begin
            if (u == 4'd0) begin
                u = 4'd9;
                t = (t == 4'd0) ? 4'd9 : t - 4'd1;
            end else begin
                u = u - 4'd1;
            end
        end
        return {t, u};
    endfunction

    // Active-low seven-segment pattern, bit order g..a.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return DASH;
        endcase
    endfunction

    // Reset asserts immediately from KEY[0] but releases two clocks later.
    always_ff @(posedge CLOCK_50 or negedge KEY[0]) begin
        if (!KEY[0]) begin
            rst_p0 <= 1'b0;
            rst_p1 <= 1'b0;
        end else begin
            rst_p0 <= 1'b1;
            rst_p1 <= rst_p0;
        end
    end

    assign rst_n = rst_p1;

    // Button synchronizer (p0/p1) plus previous-value flop (p2) for edge detect.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            key_p0 <= 3'b111;
            key_p1 <= 3'b111;
            key_p2 <= 3'b111;
        end else begin
            key_p0 <= KEY[3:1];
            key_p1 <= key_p0;
            key_p2 <= key_p1;
        end
    end

    // --- stage boundary: synchronized buttons -> press pulses ---
    assign press      = key_p2 & ~key_p1;
    assign ss_pulse   = press[0];
    assign load_pulse = press[1];
    assign dir_pulse  = press[2];
    assign sw_ok      = (SW[7:4] <= 4'd9) && (SW[3:0] <= 4'd9);

    // Control FSM, prescaler and count; load outranks start/stop, direction always applies.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= 8'h00;
            dir_up <= 1'b1;
            presc  <= '0;
        end else begin
            if (dir_pulse) begin
                dir_up <= ~dir_up;
            end
            if (load_pulse && state != RUN) begin
                presc <= '0;
                if (sw_ok) begin
                    count <= SW;
                    state <= HOLD;
                end else begin
                    state <= ERROR;
                end
            end else if (ss_pulse && state != ERROR) begin
                presc <= '0;
                state <= (state == RUN) ? HOLD : RUN;
            end else if (state == RUN) begin
                if (presc == PMAX) begin
                    presc <= '0;
                    count <= bcd_step(count, dir_up);
                end else begin
                    presc <= presc + PW'(1);
                end
            end else begin
                presc <= '0;
            end
        end
    end

    // --- stage boundary: registered state -> display decode ---
    assign LEDR = {state == ERROR, state == RUN, count};
    assign HEX1 = (state == ERROR) ? DASH : seg7(count[7:4]);
    assign HEX0 = (state == ERROR) ? DASH : seg7(count[3:0]);

endmodule

// File: tb/tb_two_digit_sequencer.sv
// Bench for two_digit_sequencer with TICK_DIV=4: every change seen on LEDR is
// matched against a queue of expected LEDR values (with derived HEX digits).
module tb_two_digit_sequencer;

    localparam int         TD   = 4;
    localparam logic [6:0] DASH = 7'b0111111;

    logic       clk = 1'b0;
    logic [3:0] key;
    logic [7:0] sw;
    logic [6:0] hex1, hex0;
    logic [9:0] ledr;

    two_digit_sequencer #(.TICK_DIV(TD)) dut (
        .CLOCK_50(clk),
        .KEY     (key),
        .SW      (sw),
        .HEX1    (hex1),
        .HEX0    (hex0),
        .LEDR    (ledr)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         t0;
    logic [9:0] exp_q[$];
    logic [9:0] last;
    bit         sb_on   = 1'b0;
    logic [6:0] seg_tb [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_hex(input logic [9:0] e, input bit hi);
        if (e[9]) return DASH;
        return hi ? seg_tb[int'(e[7:4])] : seg_tb[int'(e[3:0])];
    endfunction

    // Advance to the next falling edge and score any LEDR change.
    task automatic tick();
        logic [9:0] e;
        @(negedge clk);
        cyc++;
        if (sb_on && ledr !== last) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", {22'd0, ledr}, {22'd0, last});
            end else begin
                e = exp_q.pop_front();
                chk("sb_ledr", {22'd0, ledr}, {22'd0, e});
                chk("sb_hex1", {25'd0, hex1}, {25'd0, exp_hex(e, 1'b1)});
                chk("sb_hex0", {25'd0, hex0}, {25'd0, exp_hex(e, 1'b0)});
            end
            last = ledr;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input int k);
        key[k] = 1'b0;
        tick();
        key[k] = 1'b1;
    endtask

    task automatic wait_ledr(input logic [9:0] v, input int maxc, input string tag);
        int n = 0;
        while (ledr !== v && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, {22'd0, ledr}, {22'd0, v});
    endtask

    initial begin
        key = 4'hF;
        sw  = 8'h00;
        #3 key[0] = 1'b0;
        #1;
        chk("rst_ledr", {22'd0, ledr}, 32'h000);
        chk("rst_hex1", {25'd0, hex1}, 32'h40);
        chk("rst_hex0", {25'd0, hex0}, 32'h40);
        idle(3);
        key[0] = 1'b1;
        idle(4);
        last  = 10'h000;
        sb_on = 1'b1;

        // Start and the first two steps, with step spacing measured.
        exp_q.push_back(10'h100);
        exp_q.push_back(10'h101);
        exp_q.push_back(10'h102);
        press(1);
        wait_ledr(10'h100, 10, "run_on");
        t0 = cyc;
        wait_ledr(10'h101, 10, "step1");
        chk("step1_lat", cyc - t0, TD);
        t0 = cyc;
        wait_ledr(10'h102, 10, "step2");
        chk("step2_lat", cyc - t0, TD);
        exp_q.push_back(10'h002);
        press(1);
        wait_ledr(10'h002, 10, "stop1");
        idle(2);

        // Up-wrap from 98.
        sw = 8'h98;
        exp_q.push_back(10'h098);
        press(2);
        wait_ledr(10'h098, 10, "load98");
        idle(2);
        foreach (exp_q[i]) ;
        exp_q.push_back(10'h198);
        exp_q.push_back(10'h199);
        exp_q.push_back(10'h100);
        exp_q.push_back(10'h101);
        press(1);
        wait_ledr(10'h101, 40, "upwrap01");
        chk("up_hex1", {25'd0, hex1}, 32'h40);
        chk("up_hex0", {25'd0, hex0}, 32'h79);
        exp_q.push_back(10'h001);
        press(1);
        wait_ledr(10'h001, 10, "stop2");
        idle(2);

        // Down-wrap from 10 after a direction toggle.
        sw = 8'h10;
        exp_q.push_back(10'h010);
        press(2);
        wait_ledr(10'h010, 10, "load10");
        idle(2);
        press(3);
        idle(3);
        exp_q.push_back(10'h110);
        for (int v = 9; v >= 0; v--) exp_q.push_back(10'h100 | 10'(v));
        exp_q.push_back(10'h199);
        press(1);
        wait_ledr(10'h199, 80, "dnwrap99");
        exp_q.push_back(10'h099);
        press(1);
        wait_ledr(10'h099, 10, "stop3");
        idle(2);
        press(3);
        idle(3);

        // Invalid units nibble, ignored start, recovery.
        sw = 8'h3A;
        exp_q.push_back(10'h299);
        press(2);
        wait_ledr(10'h299, 10, "err_in");
        chk("err_hex1", {25'd0, hex1}, {25'd0, DASH});
        chk("err_hex0", {25'd0, hex0}, {25'd0, DASH});
        press(1);
        idle(8);
        chk("err_ss_ign", {22'd0, ledr}, 32'h299);
        sw = 8'h42;
        exp_q.push_back(10'h042);
        press(2);
        wait_ledr(10'h042, 10, "err_out");
        idle(2);
        // Invalid tens nibble from HOLD.
        sw = 8'hA1;
        exp_q.push_back(10'h242);
        press(2);
        wait_ledr(10'h242, 10, "err_tens");
        sw = 8'h42;
        exp_q.push_back(10'h042);
        press(2);
        wait_ledr(10'h042, 10, "err_out2");
        idle(2);

        // Load while running is ignored.
        exp_q.push_back(10'h142);
        exp_q.push_back(10'h143);
        exp_q.push_back(10'h144);
        exp_q.push_back(10'h145);
        press(1);
        wait_ledr(10'h143, 20, "run43");
        sw = 8'h55;
        press(2);
        wait_ledr(10'h145, 20, "run45");
        exp_q.push_back(10'h045);
        press(1);
        wait_ledr(10'h045, 10, "stop4");
        idle(2);

        // Reset in the middle of a run.
        sw = 8'h35;
        exp_q.push_back(10'h035);
        press(2);
        wait_ledr(10'h035, 10, "load35");
        idle(2);
        exp_q.push_back(10'h135);
        exp_q.push_back(10'h136);
        exp_q.push_back(10'h137);
        press(1);
        wait_ledr(10'h137, 20, "run37");
        exp_q.push_back(10'h000);
        key[0] = 1'b0;
        #1;
        chk("mid_rst_ledr", {22'd0, ledr}, 32'h000);
        chk("mid_rst_hex1", {25'd0, hex1}, 32'h40);
        chk("mid_rst_hex0", {25'd0, hex0}, 32'h40);
        idle(3);
        key[0] = 1'b1;
        idle(12);
        chk("no_step", {22'd0, ledr}, 32'h000);
        exp_q.push_back(10'h100);
        exp_q.push_back(10'h101);
        press(1);
        wait_ledr(10'h101, 20, "rerun01");
        exp_q.push_back(10'h001);
        press(1);
        wait_ledr(10'h001, 10, "stop5");
        idle(4);
        chk("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/two_digit_sequencer.md
TWO_DIGIT_SEQUENCER -- requirements
Module: two_digit_sequencer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50_000_000, the number of CLOCK_50 cycles per count step; legal range is 2 or more.
REQ-002 The block SHALL have port CLOCK_50, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port KEY, input, 4 bits: push-buttons, active-low (0 = pressed).
  - KEY[0] = asynchronous active-low reset.
  - KEY[1] = start/stop.
  - KEY[2] = load.
  - KEY[3] = direction toggle.
REQ-004 The block SHALL have port SW, input, 8 bits: load value; SW[7:4] = tens BCD, SW[3:0] = units BCD.
REQ-005 The block SHALL have port HEX1, output, 7 bits: tens digit, active-low seven-segment, bit order g..a.
REQ-006 The block SHALL have port HEX0, output, 7 bits: units digit, same encoding as HEX1.
REQ-007 The block SHALL have port LEDR, output, 10 bits: status.
  - LEDR[7:0] = current count, packed BCD.
  - LEDR[8] = running.
  - LEDR[9] = load error.

Function
REQ-008 The block SHALL pass KEY[3:1] through a 2-flop synchronizer and SHALL generate a one-cycle press pulse on each synchronized 1->0 transition, so a press acts 2-3 cycles after the pin falls.
REQ-009 The block SHALL keep the count as two BCD digits (tens, units), each always in 0..9.
REQ-010 The block SHALL implement states IDLE, RUN, HOLD and ERROR.
REQ-011 A start/stop pulse SHALL move the FSM as follows:
  - IDLE->RUN.
  - RUN->HOLD.
  - HOLD->RUN.
  - In ERROR it SHALL be ignored.
REQ-012 A load pulse in IDLE, HOLD or ERROR SHALL act as follows:
  - Both SW nibbles 9 or less: count := SW, next state HOLD.
  - Either nibble greater than 9: count unchanged, next state ERROR.
REQ-013 A load pulse in RUN SHALL be ignored.
REQ-014 A direction pulse SHALL toggle the count direction (up/down) in every state; after reset the direction is up.
REQ-015 A prescaler SHALL count 0..TICK_DIV-1 only while in RUN, and SHALL be cleared on every entry into RUN and while in any other state.
REQ-016 When the prescaler equals TICK_DIV-1 in RUN, the count SHALL step by one in the current direction.
  - The first step occurs exactly TICK_DIV cycles after entering RUN.
REQ-017 Count wrap SHALL be BCD: up 09->10, up 99->00, down 10->09, down 00->99.
REQ-018 Pulses arriving on the same cycle SHALL be prioritized load > start/stop.
  - The lower-priority start/stop pulse is dropped.
  - The direction pulse is always applied, independent of load and start/stop.
REQ-019 A direction toggle on the same cycle as a step SHALL take effect from the next step; the current step uses the old direction.
REQ-020 HEX1 and HEX0 SHALL show standard digits for 0-9 (0 = 1000000, 1 = 1111001, ..., 9 = 0010000).
REQ-021 In ERROR, HEX1 and HEX0 SHALL both show dash (0111111); LEDR[7:0] continues to show the retained count.
REQ-022 LEDR[8] SHALL be 1 exactly when in RUN, and LEDR[9] SHALL be 1 exactly when in ERROR.
REQ-023 HEX1, HEX0 and LEDR SHALL be registered or decoded only from registered state, with no combinational path from SW or KEY.

Reset
REQ-024 KEY[0]=0 SHALL asynchronously force:
  - state IDLE, count 00, direction up;
  - prescaler 0, synchronizer flops 1.
REQ-025 The reset values of the outputs SHALL be HEX1 = HEX0 = 1000000 and LEDR = 10'b0000000000.
REQ-026 Reset SHALL be released synchronously internally (2-flop deassertion synchronizer); assertion mid-count SHALL abort any step in progress.

Verification (TICK_DIV=4)
REQ-027 The bench SHALL cover reset, start and first step:
  - Reset, then press KEY[1] -> LEDR[8]=1.
  - LEDR[7:0] goes 00->01 four cycles after RUN entry, then 02 four cycles later.
REQ-028 The bench SHALL cover up-wrap: SW=0x98, press KEY[2], press KEY[1] -> count 98, 99, 00, 01; HEX1=1000000, HEX0=1111001 at 01.
REQ-029 The bench SHALL cover down-wrap: load 0x10, press KEY[3], press KEY[1] -> count 10, 09, 00, 99.
REQ-030 The bench SHALL cover invalid load and recovery:
  - SW=0x3A, press KEY[2] -> LEDR[9]=1, both HEX = 0111111, LEDR[7:0] unchanged.
  - Press KEY[1] -> no change.
  - SW=0x42, press KEY[2] -> LEDR[9]=0, count 42, HOLD.
REQ-031 The bench SHALL cover load during RUN: press KEY[2] with SW=0x55 -> ignored, count keeps stepping.
REQ-032 The bench SHALL cover reset mid-run: assert KEY[0] at count 37 -> immediately count 00, LEDR=0, HEX1/HEX0 = 1000000; no step until the next KEY[1] press.
